// File: rtl/writeback_stage.sv
// Final pipeline stage: registers EX/WB results onto the RegisterFile write port,
// tracks in-flight destinations for hazard stalls, and keeps sticky FP status.
module writeback_stage #(
   parameter int DSIZE = 32,
   parameter int ASIZE = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   input  logic [ASIZE-1:0] issue_rl,
   input  logic [ASIZE-1:0] issue_rr,
   input  logic [ASIZE-1:0] issue_rd,
   output logic             stall,
   input  logic             wb_valid,
   input  logic [ASIZE-1:0] wb_rd,
   input  logic [DSIZE-1:0] wb_data,
   input  logic [3:0]       wb_exc,
   output logic             rf_we,
   output logic [ASIZE-1:0] rf_waddr,
   output logic [DSIZE-1:0] rf_wdata,
   input  logic             status_clr,
   output logic [3:0]       status,
   output logic             sb_err,
   output logic [CNT_W-1:0] retired
);

   localparam int DEPTH = 2 ** ASIZE;

   logic [DEPTH-1:0] pending;
   logic [DEPTH-1:0] pendingNext;
   logic             accept;

   // Issue handshake: issue_valid is the offer, ~stall is the ready; an issue
   // transfers on a cycle where both hold, and Decode must keep its fields
   // stable while stall is high. stall never rises without issue_valid.
   assign stall  = issue_valid &
                   (pending[issue_rl] | pending[issue_rr] | pending[issue_rd]);
   assign accept = issue_valid & ~stall;

   // Clear is applied first so that a set on the same index wins.
   always_comb begin
      pendingNext = pending;
      if (rf_we)  pendingNext[rf_waddr] = 1'b0;
      if (accept) pendingNext[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending  <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         status   <= 4'b0;
         sb_err   <= 1'b0;
         retired  <= '0;
      end else begin
         pending <= pendingNext;
         rf_we   <= wb_valid;
         if (wb_valid) begin
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
         end
         // A result for a register nobody is waiting on is still written.
         if (wb_valid && !pending[wb_rd]) sb_err <= 1'b1;
         status <= (status_clr ? 4'b0 : status) | (wb_valid ? wb_exc : 4'b0);
         if (rf_we && (retired != {CNT_W{1'b1}})) retired <= retired + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: hazard stall table, commit scoreboard, status,
// sb_err, reset and retired-counter saturation sequences.
module tb_writeback_stage;

   localparam int DSIZE = 32;
   localparam int ASIZE = 5;
   localparam int CNT_W = 5;
   localparam int W     = ASIZE + DSIZE;
   localparam int RMAX  = 31;

   logic             clk;
   logic             rst_n;
   logic             issue_valid;
   logic [ASIZE-1:0] issue_rl, issue_rr, issue_rd;
   logic             stall;
   logic             wb_valid;
   logic [ASIZE-1:0] wb_rd;
   logic [DSIZE-1:0] wb_data;
   logic [3:0]       wb_exc;
   logic             rf_we;
   logic [ASIZE-1:0] rf_waddr;
   logic [DSIZE-1:0] rf_wdata;
   logic             status_clr;
   logic [3:0]       status;
   logic             sb_err;
   logic [CNT_W-1:0] retired;

   int checks = 0;
   int errors = 0;
   int expRetired = 0;
   logic [W-1:0] expQ[$];

   typedef struct {
      logic             v;
      logic [ASIZE-1:0] rl, rr, rd;
      logic             expStall;
   } stallVec_t;
   stallVec_t vecs[8];

   writeback_stage #(.DSIZE(DSIZE), .ASIZE(ASIZE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_rl(issue_rl), .issue_rr(issue_rr),
      .issue_rd(issue_rd), .stall(stall),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .status_clr(status_clr), .status(status), .sb_err(sb_err),
      .retired(retired)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      wb_valid    = 1'b0;
      wb_exc      = 4'b0;
      status_clr  = 1'b0;
   endtask

   task automatic issue(input logic [ASIZE-1:0] rl, input logic [ASIZE-1:0] rr,
                        input logic [ASIZE-1:0] rd);
      issue_valid = 1'b1;
      issue_rl    = rl;
      issue_rr    = rr;
      issue_rd    = rd;
   endtask

   task automatic driveWb(input logic [ASIZE-1:0] rd, input logic [DSIZE-1:0] data,
                          input logic [3:0] exc);
      wb_valid = 1'b1;
      wb_rd    = rd;
      wb_data  = data;
      wb_exc   = exc;
      if (rst_n) begin
         expQ.push_back({rd, data});
         expRetired++;
      end
   endtask

   function automatic logic [63:0] satRetired();
      return 64'((expRetired > RMAX) ? RMAX : expRetired);
   endfunction

   // scoreboard: every RF write must match the oldest outstanding result
   initial begin : monitor
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (rf_we) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0d expected no write", rf_waddr);
            end else begin
               e = expQ.pop_front();
               chk("commit", 64'({rf_waddr, rf_wdata}), 64'(e));
            end
         end
      end
   end

   initial begin : stimulus
      logic [DSIZE-1:0] d;

      vecs[0] = '{1'b0, 5'd10, 5'd20, 5'd31, 1'b0};
      vecs[1] = '{1'b1, 5'd10, 5'd1,  5'd2,  1'b1};
      vecs[2] = '{1'b1, 5'd1,  5'd20, 5'd2,  1'b1};
      vecs[3] = '{1'b1, 5'd1,  5'd2,  5'd31, 1'b1};
      vecs[4] = '{1'b1, 5'd0,  5'd1,  5'd2,  1'b1};
      vecs[5] = '{1'b1, 5'd1,  5'd2,  5'd3,  1'b0};
      vecs[6] = '{1'b1, 5'd11, 5'd21, 5'd30, 1'b0};
      vecs[7] = '{1'b1, 5'd9,  5'd19, 5'd29, 1'b0};

      rst_n = 1'b0;
      idle();
      issue_rl = '0; issue_rr = '0; issue_rd = '0;
      wb_rd = '0; wb_data = '0;
      step();
      step();
      chk("reset_rf_we", 64'(rf_we), 64'(0));
      chk("reset_rf_waddr", 64'(rf_waddr), 64'(0));
      chk("reset_rf_wdata", 64'(rf_wdata), 64'(0));
      chk("reset_status", 64'(status), 64'(0));
      chk("reset_sb_err", 64'(sb_err), 64'(0));
      chk("reset_retired", 64'(retired), 64'(0));
      issue(5'd9, 5'd9, 5'd9);
      #1 chk("reset_stall", 64'(stall), 64'(0));
      idle();
      rst_n = 1'b1;
      step();

      // RAW on register 3
      issue(5'd1, 5'd2, 5'd3);
      #1 chk("raw_first_issue", 64'(stall), 64'(0));
      step();
      issue(5'd3, 5'd0, 5'd4);
      #1 chk("raw_stall", 64'(stall), 64'(1));
      d = 32'h3F800000;
      driveWb(5'd3, d, 4'b0);
      step();
      wb_valid = 1'b0;
      chk("raw_rf_we", 64'(rf_we), 64'(1));
      chk("raw_rf_waddr", 64'(rf_waddr), 64'(3));
      chk("raw_rf_wdata", 64'(rf_wdata), 64'(d));
      #1 chk("raw_no_bypass", 64'(stall), 64'(1));
      step();
      chk("raw_release", 64'(stall), 64'(0));
      chk("raw_retired", 64'(retired), 64'(1));
      issue_valid = 1'b0;

      // WAW on register 5
      issue(5'd0, 5'd0, 5'd5);
      step();
      chk("waw_stall", 64'(stall), 64'(1));
      step();
      chk("waw_hold", 64'(stall), 64'(1));
      driveWb(5'd5, $urandom, 4'b0);
      step();
      wb_valid = 1'b0;
      chk("waw_rf_we", 64'(rf_we), 64'(1));
      #1 chk("waw_hold_at_write", 64'(stall), 64'(1));
      step();
      chk("waw_release", 64'(stall), 64'(0));
      step();
      chk("waw_reissued", 64'(stall), 64'(1));
      issue_valid = 1'b0;
      driveWb(5'd5, $urandom, 4'b0);
      step();
      wb_valid = 1'b0;
      step();
      chk("waw_retired", 64'(retired), satRetired());

      // back-to-back commits
      for (int i = 1; i <= 4; i++) begin
         issue(5'd0, 5'd0, ASIZE'(i));
         step();
      end
      issue_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         d = $urandom;
         driveWb(ASIZE'(i), d, 4'b0);
         step();
         chk("burst_rf_we", 64'(rf_we), 64'(1));
         chk("burst_rf_waddr", 64'(rf_waddr), 64'(i));
         chk("burst_rf_wdata", 64'(rf_wdata), 64'(d));
      end
      wb_valid = 1'b0;
      step();
      chk("burst_end", 64'(rf_we), 64'(0));
      step();
      chk("burst_retired", 64'(retired), satRetired());
      issue(5'd1, 5'd2, 5'd3);
      #1 chk("burst_clear_a", 64'(stall), 64'(0));
      issue(5'd4, 5'd4, 5'd4);
      #1 chk("burst_clear_b", 64'(stall), 64'(0));
      idle();

      // sticky status and clear
      issue(5'd0, 5'd0, 5'd6);  step();
      issue(5'd0, 5'd0, 5'd8);  step();
      issue(5'd0, 5'd0, 5'd10); step();
      issue_valid = 1'b0;
      driveWb(5'd6, $urandom, 4'b0100); step();
      driveWb(5'd8, $urandom, 4'b0001); step();
      chk("status_or", 64'(status), 64'(4'b0101));
      driveWb(5'd10, $urandom, 4'b1000);
      status_clr = 1'b1;
      step();
      chk("status_clr_new", 64'(status), 64'(4'b1000));
      idle();
      status_clr = 1'b1;
      step();
      chk("status_clr", 64'(status), 64'(0));
      status_clr = 1'b0;
      step();
      chk("sb_err_clean", 64'(sb_err), 64'(0));
      chk("status_retired", 64'(retired), satRetired());

      // write to a register that is not pending
      driveWb(5'd7, $urandom, 4'b0);
      step();
      wb_valid = 1'b0;
      chk("sb_err_rf_we", 64'(rf_we), 64'(1));
      chk("sb_err_rf_waddr", 64'(rf_waddr), 64'(7));
      chk("sb_err_set", 64'(sb_err), 64'(1));
      repeat (3) step();
      chk("sb_err_sticky", 64'(sb_err), 64'(1));

      // stall table over pending = {0, 10, 20, 31}
      issue(5'd0, 5'd0, 5'd10); step();
      issue(5'd0, 5'd0, 5'd20); step();
      issue(5'd0, 5'd0, 5'd31); step();
      issue(5'd0, 5'd0, 5'd0);  step();
      for (int i = 0; i < 8; i++) begin
         issue_valid = vecs[i].v;
         issue_rl    = vecs[i].rl;
         issue_rr    = vecs[i].rr;
         issue_rd    = vecs[i].rd;
         #1 chk($sformatf("stall_vec%0d", i), 64'(stall), 64'(vecs[i].expStall));
      end
      issue_valid = 1'b0;
      driveWb(5'd10, $urandom, 4'b0010); step();
      driveWb(5'd20, $urandom, 4'b0);    step();
      driveWb(5'd31, $urandom, 4'b0);    step();
      driveWb(5'd0,  $urandom, 4'b0);    step();
      wb_valid = 1'b0;
      wb_exc   = 4'b0;
      step();
      step();
      chk("table_retired", 64'(retired), satRetired());
      chk("table_status", 64'(status), 64'(4'b0010));
      issue(5'd10, 5'd20, 5'd31);
      #1 chk("table_clear_a", 64'(stall), 64'(0));
      issue(5'd0, 5'd0, 5'd0);
      #1 chk("table_clear_b", 64'(stall), 64'(0));
      idle();

      // reset with a pending register and an in-flight result
      issue(5'd0, 5'd0, 5'd9);
      step();
      issue(5'd9, 5'd0, 5'd1);
      #1 chk("pre_reset_stall", 64'(stall), 64'(1));
      issue_valid = 1'b0;
      rst_n = 1'b0;
      driveWb(5'd9, $urandom, 4'b1111);
      step();
      rst_n = 1'b1;
      idle();
      expRetired = 0;
      chk("rst_rf_we", 64'(rf_we), 64'(0));
      chk("rst_rf_waddr", 64'(rf_waddr), 64'(0));
      chk("rst_rf_wdata", 64'(rf_wdata), 64'(0));
      chk("rst_retired", 64'(retired), 64'(0));
      chk("rst_status", 64'(status), 64'(0));
      chk("rst_sb_err", 64'(sb_err), 64'(0));
      issue(5'd9, 5'd0, 5'd1);
      #1 chk("rst_stall", 64'(stall), 64'(0));
      idle();
      step();

      // retired saturation with continuous back-to-back commits
      for (int i = 0; i < RMAX + 4; i++) begin
         driveWb(5'd7, $urandom, 4'b0);
         step();
         if (i == 10) chk("sat_midway", 64'(retired), 64'(i));
      end
      wb_valid = 1'b0;
      step();
      step();
      chk("retired_saturate", 64'(retired), satRetired());
      chk("sat_sb_err", 64'(sb_err), 64'(1));

      step();
      chk("queue_drained", 64'(expQ.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage after the EX/WB buffer; commits EXE results to the RegisterFile write port.
- Maintains a per-register pending-write scoreboard. Decode consults it to stall on RAW and WAW hazards.
- Accumulates sticky FP exception status from EXE and counts retired instructions.

Parameters:
DSIZE, 32, data width (matches `DSIZE)
ASIZE, 5, register address width (matches `ASIZE); scoreboard depth = 2**ASIZE
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
issue_valid  input  1  Decode presents an instruction this cycle
issue_rl  input  ASIZE  left source register of issuing instruction
issue_rr  input  ASIZE  right source register of issuing instruction
issue_rd  input  ASIZE  destination register of issuing instruction
stall  output  1  combinational; Decode must hold its instruction when high
wb_valid  input  1  EX/WB buffer holds a valid result
wb_rd  input  ASIZE  destination address from EX/WB buffer
wb_data  input  DSIZE  result from EX/WB buffer
wb_exc  input  4  EXE exception bits {invalid, overflow, underflow, inexact}
rf_we  output  1  RegisterFile write enable (registered)
rf_waddr  output  ASIZE  RegisterFile write address (registered)
rf_wdata  output  DSIZE  RegisterFile write data (registered)
status_clr  input  1  clear sticky status
status  output  4  sticky OR of committed wb_exc
sb_err  output  1  sticky: writeback to a register not marked pending
retired  output  CNT_W  count of committed writes, saturating

Behaviour:
- Reset, on a clk edge with rst_n=0: pending[] = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, status = 0, sb_err = 0, retired = 0.
  - An in-flight wb is discarded.
  - stall is 0 after reset because pending is empty.
- Stall (combinational from registered pending):
  - stall = issue_valid & (pending[issue_rl] | pending[issue_rr] | pending[issue_rd]).
  - There is no same-cycle bypass of a concurrent clear.
  - stall is never asserted while issue_valid = 0.
- Issue acceptance:
  - accept = issue_valid & ~stall.
  - On accept, pending[issue_rd] is set at the next edge.
  - rd equal to rl or rr is legal and sets pending.
- Commit pipeline, 1-cycle latency:
  - Every edge: rf_we <= wb_valid. When wb_valid, rf_waddr <= wb_rd and rf_wdata <= wb_data.
  - When wb_valid = 0, rf_waddr and rf_wdata hold their previous values.
- Scoreboard clear:
  - When rf_we = 1, pending[rf_waddr] is cleared at the same edge the RegisterFile writes.
  - A dependent issue therefore proceeds in the cycle after the RF write and reads the new value.
- Simultaneous set and clear on the same index cannot both apply: a set requires pending = 0, and a clear implies pending = 1.
  - If both are requested anyway because of an sb_err condition, the set wins.
- sb_err is set when wb_valid = 1 and pending[wb_rd] = 0 at capture time. The write is still performed. Cleared only by reset.
- Status:
  - status <= (status_clr ? 0 : status) | (wb_valid ? wb_exc : 0).
  - A new exception arriving in the clear cycle survives.
- retired increments on each edge where rf_we = 1 and saturates at 2**CNT_W - 1.
- Back-to-back wb_valid every cycle is supported with no bubbles.
- All 2**ASIZE registers, including address 0, are ordinary registers.

Test Plan:
- Reset, then issue rd=3, rl=1, rr=2 -> stall=0; next cycle pending[3]=1. Issue rl=3 -> stall=1. wb_valid with wb_rd=3, wb_data=32'h3F800000 -> next cycle rf_we=1, rf_waddr=3. The cycle after, stall=0 and retired=1.
- WAW: issue rd=5, then issue rd=5 again -> stall=1 until rf_we for address 5 has occurred; the second issue is accepted one cycle after that.
- Four consecutive wb_valid cycles to rd=1,2,3,4, all pending -> rf_we high for 4 consecutive cycles with matching addresses and data; retired=4; pending all clear.
- wb_exc=4'b0100 then 4'b0001 -> status=4'b0101. status_clr asserted in the same cycle as wb_exc=4'b1000 -> status=4'b1000.
- wb_valid to rd=7 with pending[7]=0 -> rf_we=1 at address 7 next cycle; sb_err=1 and stays 1 until reset.
- rst_n=0 for one edge with pending[9]=1 and wb_valid=1 -> next cycle rf_we=0, pending empty, retired=0, status=0, stall=0 for an issue with rl=9.
